// File: rtl/sec_decoder_awe_30bits_clk.sv
// Sequential SEC decoder for the AN code with A = 79: bit-serial residue, error search,
// +/-2^j correction, then restoring division by 79 to recover N.
module sec_decoder_awe_30bits_clk #(
  parameter int unsigned W_BITS = 38,
  parameter int unsigned N_BITS = 31,
  parameter int unsigned A      = 79
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_BITS-1:0] W,
  output logic              found,
  output logic [N_BITS-1:0] N
);

  localparam int unsigned R_BITS = $clog2(A);
  localparam int unsigned C_BITS = W_BITS + 1;
  localparam int unsigned K_BITS = $clog2(W_BITS + 1);
  localparam logic [R_BITS:0]   A_EXT  = (R_BITS+1)'(A);
  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(W_BITS - 1);
  localparam logic [K_BITS-1:0] K_DIV  = K_BITS'(W_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOD    = 3'd1,
    SEARCH = 3'd2,
    CORR   = 3'd3,
    DIV    = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [W_BITS-1:0]   w_q, w_d;
  logic [R_BITS-1:0]   r_q, r_d;
  logic [R_BITS-1:0]   p_q, p_d;
  logic [R_BITS-1:0]   rem_q, rem_d;
  logic [K_BITS-1:0]   cnt_q, cnt_d;
  logic                hit_q, hit_d;
  logic                neg_q, neg_d;
  logic [C_BITS-1:0]   c_q, c_d;
  logic [N_BITS-1:0]   n_q, n_d;

  // Datapath helpers: residue step, power-of-two residue step, correction, division step
  logic [R_BITS:0]   mod_t, mod_r, p_dbl, p_nxt, div_t, div_r;
  logic [R_BITS-1:0] neg_p;
  logic [C_BITS-1:0] w_ext, pow, c_corr;
  logic              q_bit;

  always_comb begin
    mod_t  = {r_q, w_q[cnt_q]};
    mod_r  = (mod_t >= A_EXT) ? mod_t - A_EXT : mod_t;
    p_dbl  = {p_q, 1'b0};
    p_nxt  = (p_dbl >= A_EXT) ? p_dbl - A_EXT : p_dbl;
    neg_p  = R_BITS'(A_EXT - {1'b0, p_q});
    w_ext  = {1'b0, w_q};
    pow    = C_BITS'(1) << cnt_q;
    if (!hit_q)          c_corr = w_ext;
    else if (neg_q)      c_corr = w_ext + pow;
    else if (w_ext < pow) c_corr = w_ext;
    else                 c_corr = w_ext - pow;
    div_t  = {rem_q, c_q[C_BITS-1]};
    q_bit  = (div_t >= A_EXT);
    div_r  = q_bit ? div_t - A_EXT : div_t;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    p_d     = p_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    neg_d   = neg_q;
    c_d     = c_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == IDLE || W != w_q) begin
          state_d = MOD;
          w_d     = W;
          r_d     = '0;
          p_d     = R_BITS'(1);
          rem_d   = '0;
          cnt_d   = K_LAST;
          hit_d   = 1'b0;
          neg_d   = 1'b0;
          c_d     = '0;
        end
      end
      MOD: begin
        r_d = mod_r[R_BITS-1:0];
        if (cnt_q == '0) begin
          state_d = SEARCH;
          p_d     = R_BITS'(1);
        end else begin
          cnt_d = cnt_q - K_BITS'(1);
        end
      end
      SEARCH: begin
        if (r_q == '0) begin
          state_d = CORR;
        end else if (r_q == p_q) begin
          state_d = CORR;
          hit_d   = 1'b1;
        end else if (r_q == neg_p) begin
          state_d = CORR;
          hit_d   = 1'b1;
          neg_d   = 1'b1;
        end else if (cnt_q == K_LAST) begin
          state_d = CORR;
        end else begin
          p_d   = p_nxt[R_BITS-1:0];
          cnt_d = cnt_q + K_BITS'(1);
        end
      end
      CORR: begin
        c_d     = c_corr;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        c_d   = {c_q[C_BITS-2:0], q_bit};
        rem_d = div_r[R_BITS-1:0];
        cnt_d = cnt_q + K_BITS'(1);
        if (cnt_q == K_DIV) begin
          state_d = DONE;
          n_d     = c_d[N_BITS-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      neg_q   <= 1'b0;
      c_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      r_q     <= r_d;
      p_q     <= p_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
      n_q     <= n_d;
    end
  end

  // found tracks the live input so a changed W is never reported as decoded
  assign found = (state_q == DONE) && (W == w_q);
  assign N     = n_q;

endmodule

// File: tb/tb_sec_decoder_awe_30bits_clk.sv
// Directed bench for the A = 79 SEC decoder with hand-computed data words.
module tb_sec_decoder_awe_30bits_clk;

  logic        clk;
  logic        rst_n;
  logic [37:0] W;
  logic        found;
  logic [30:0] N;

  int unsigned n_pass;
  int unsigned n_total;

  sec_decoder_awe_30bits_clk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (W),
    .found (found),
    .N     (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_found(input string tag, input logic [63:0] exp_n);
    int n;
    n = 0;
    while (!found && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_found"}, 64'(found), 64'd1);
    chk({tag, "_N"}, 64'(N), exp_n);
  endtask

  task automatic run(input string tag, input logic [63:0] w, input logic [63:0] exp_n);
    @(negedge clk);
    W = 38'(w);
    #1;
    chk({tag, "_drop"}, 64'(found), 64'd0);
    wait_found(tag, exp_n);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    W       = '0;
    repeat (2) @(negedge clk);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_N", 64'(N), 64'd0);
    rst_n = 1'b1;
    wait_found("zero", 64'd0);

    run("clean",   64'd84825604017,  64'd1073741823);
    run("pos_lsb", 64'd84825604018,  64'd1073741823);
    run("neg_mid", 64'd84824555441,  64'd1073741823);
    run("pos_msb", 64'd222264557489, 64'd1073741823);
    run("neg_lsb", 64'd78,           64'd1);
    run("neg_msb", 64'd32212254641,  64'd2147483647);
    run("b2b_a",   64'd84825604018,  64'd1073741823);
    run("b2b_b",   64'd399,          64'd5);

    // Abort a decode while it is dividing, then let it restart with W held
    @(negedge clk);
    W = 38'(64'd84825604017);
    repeat (60) @(negedge clk);
    chk("mid_busy", 64'(found), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_found", 64'(found), 64'd0);
    chk("mid_rst_N", 64'(N), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_found("restart", 64'd1073741823);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
